// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin arbitrating mux with a one-entry registered
// output stage. One valid channel is granted each cycle, starting the search at
// the priority pointer. The granted beat is captured into the output register,
// which uses a valid/ready handshake toward the consumer.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   [N]        per-channel valid
//   in_data    [N*WIDTH]  flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   [N]        per-channel ready, combinational, at most one bit high
//   out_valid             output register holds a beat
//   out_data   [WIDTH]    registered data of the selected beat
//   out_sel    [SELW]     index of the channel that supplied out_data
//   out_ready             consumer accepts when out_valid && out_ready
module rr_arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    // One extra bit so ptr + offset never overflows before the wrap check.
    localparam int unsigned CW = SELW + 1;

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_eff;
    logic [CW-1:0]   cand;
    logic [SELW-1:0] gnt_idx;
    logic            gnt_found;
    logic            load_en;
    logic            accept;

    // Output register can take a new beat when empty or draining this cycle.
    assign load_en = !out_valid || out_ready;
    assign accept  = gnt_found && load_en && !rst;

    // Round-robin search from ptr; an out-of-range ptr is treated as 0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        ptr_eff   = (32'(ptr) >= 32'(N)) ? '0 : ptr;
        for (int k = 0; k < int'(N); k++) begin
            cand = CW'(ptr_eff) + CW'(k);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!gnt_found && in_valid[cand[SELW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[SELW-1:0];
            end
        end
    end

    // Ready goes only to the granted channel, and never during reset.
    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Output register and priority pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (gnt_found) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(gnt_idx)*int'(WIDTH) +: WIDTH];
                out_sel   <= gnt_idx;
                // Explicit wrap so non-power-of-two N never yields index N.
                ptr       <= (gnt_idx == SELW'(N - 1)) ? '0 : SELW'(gnt_idx + 1'b1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

    logic         clk;
    logic         rst;

    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    logic [2:0]   in_valid3;
    logic [95:0]  in_data3;
    logic [2:0]   in_ready3;
    logic         out_valid3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic         out_ready3;

    int n_tests;
    int n_fail;

    rr_arb_mux #(.WIDTH(32), .N(4)) u4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(32), .N(3)) u3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3),
        .out_ready(out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        in_valid3 = '0;
        out_ready = 1'b1;
        out_ready3 = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_tests++;
            if (in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_ready cyc=%0d got %b exp 0000", c, in_ready);
            end
            tick();
        end
        rst = 1'b0;
        in_valid = '0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_out got v=%b d=%h s=%0d exp v=0 d=0 s=0", out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy [5];
        exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0010; exp_rdy[2] = 4'b0100;
        exp_rdy[3] = 4'b1000; exp_rdy[4] = 4'b0001;
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if (in_ready !== exp_rdy[c]) begin
                n_fail++;
                $display("FAIL rr_ready cyc=%0d got %b exp %b", c, in_ready, exp_rdy[c]);
            end
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_sel !== 2'(c % 4) || out_data !== 32'hA0 + 32'(c % 4)) begin
                n_fail++;
                $display("FAIL rr_out cyc=%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                         c, out_valid, out_sel, out_data, c % 4, 32'hA0 + 32'(c % 4));
            end
        end
        in_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        in_data[2*32 +: 32] = 32'hDEADBEEF;
        in_data[3*32 +: 32] = 32'h33333333;
        in_valid = 4'b0100;
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_capture_ready got %b exp 0100", in_ready);
        end
        tick();
        in_valid = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_stall_ready cyc=%0d got %b exp 0000", c, in_ready);
            end
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_sel !== 2'd2) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h s=%0d exp v=1 d=deadbeef s=2",
                         c, out_valid, out_data, out_sel);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_release_ready got %b exp 1000", in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h33333333 || out_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL bp_next got v=%b d=%h s=%0d exp v=1 d=33333333 s=3", out_valid, out_data, out_sel);
        end
        in_valid = '0;
    endtask

    task automatic test_skip_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hB0 + 32'(i);
        out_ready = 1'b1;
        in_valid = 4'b0100;
        tick();                          // ch2 accepted, ptr -> 3
        in_valid = 4'b0010;
        #1;
        n_tests++;
        if (in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL skip_ready got %b exp 0010", in_ready);
        end
        tick();
        n_tests++;
        if (out_sel !== 2'd1 || out_data !== 32'hB1) begin
            n_fail++;
            $display("FAIL skip_out got s=%0d d=%h exp s=1 d=b1", out_sel, out_data);
        end
        in_valid = 4'b1111;              // ptr should now be 2
        #1;
        n_tests++;
        if (in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL skip_ptr got %b exp 0100", in_ready);
        end
        in_valid = 4'b0001;
        #1;
        n_tests++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_ready got %b exp 0001", in_ready);
        end
        tick();
        n_tests++;
        if (out_sel !== 2'd0 || out_data !== 32'hB0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_out got v=%b s=%0d d=%h exp v=1 s=0 d=b0", out_valid, out_sel, out_data);
        end
        in_valid = '0;
    endtask

    task automatic test_non_pow2();
        do_reset();
        for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = 32'hC0 + 32'(i);
        in_valid3 = 3'b111;
        out_ready3 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (out_valid3 !== 1'b1 || out_sel3 !== 2'(c % 3) || out_data3 !== 32'hC0 + 32'(c % 3)) begin
                n_fail++;
                $display("FAIL np2_out cyc=%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                         c, out_valid3, out_sel3, out_data3, c % 3, 32'hC0 + 32'(c % 3));
            end
        end
        in_valid3 = '0;
    endtask

    task automatic test_idle_reset();
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hD0 + 32'(i);
        out_ready = 1'b1;
        in_valid = 4'b0010;
        tick();
        in_valid = 4'b0000;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'hD1 || out_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL idle_out got v=%b d=%h s=%0d exp v=0 d=d1 s=1", out_valid, out_data, out_sel);
        end
        in_valid = 4'b0100;
        out_ready = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hD2) begin
            n_fail++;
            $display("FAIL mid_pre got v=%b d=%h exp v=1 d=d2", out_valid, out_data);
        end
        rst = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_rst_ready got %b exp 0000", in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_rst_out got v=%b d=%h exp v=0 d=0", out_valid, out_data);
        end
        n_tests++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_rst_grant got %b exp 0001", in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'hD0) begin
            n_fail++;
            $display("FAIL mid_rst_next got v=%b s=%0d d=%h exp v=1 s=0 d=d0", out_valid, out_sel, out_data);
        end
        in_valid = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b1;
        in_valid3 = '0;
        in_data3 = '0;
        out_ready3 = 1'b1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_skip_wrap();
        test_non_pow2();
        test_idle_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- N-channel registered arbitrating mux. It is the parametrised successor to the pipeline's fixed 3-way select mux.
- It selects one of N valid/ready input channels using round-robin priority. The selected beat goes through a one-entry output register with a valid/ready handshake.
- Used wherever several producers share one downstream port, for example writeback sources or memory request sources feeding a single pipeline stage.

Parameters:
- WIDTH, 32, data width per channel in bits.
- N, 4, number of input channels; legal range 2..16; need not be a power of two.
- SELW, $clog2(N), width of the channel index (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready; at most one bit is high in any cycle.
- out_valid  output  1  output register holds a valid beat.
- out_data  output  WIDTH  registered data of the selected beat.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts the beat when out_valid && out_ready.

Behaviour:
- Reset: when rst=1 at a clock edge, out_valid=0, out_data=0, out_sel=0, and the priority pointer ptr=0. While rst=1, in_ready is forced to all zeros combinationally.
- Load enable: load_en = !out_valid || out_ready. The output register may take a new beat in the same cycle the old one drains.
- Grant:
  - Search channels in order ptr, ptr+1, …, N-1, 0, …, ptr-1 and grant the first one with in_valid set.
  - Grant is combinational. in_ready[g] = load_en && !rst for the granted channel g only; all other in_ready bits are 0.
- Transfer: a beat is accepted from channel g when in_valid[g] && in_ready[g]. At that clock edge:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - ptr <= (g == N-1) ? 0 : g+1, i.e. wrap at N-1 to 0 for any N, not modulo 2^SELW.
- Idle load: if load_en=1 and no in_valid bit is set, out_valid <= 0. out_data, out_sel and ptr hold their values.
- Stall: if out_valid=1 and out_ready=0, then out_valid, out_data and out_sel are held stable, all in_ready bits are 0, and ptr holds.
- Latency and throughput: 1 cycle from input acceptance to out_valid. Sustains 1 beat per cycle when out_ready is held at 1.
- Fairness: ptr moves only on an accepted beat. A channel that holds in_valid high is granted within N accepted beats.
- Combinational paths:
  - in_ready depends combinationally on out_ready, out_valid, in_valid and rst.
  - out_valid, out_data and out_sel are register outputs only.
- Input stability: inputs may change in_valid/in_data while not granted. The block does not depend on a channel holding its data once that channel has been accepted.
- Reset mid-operation: a pending out_valid beat is discarded and ptr returns to 0. In the reset cycle no input is accepted, since in_ready is 0.
- Out-of-range state: ptr values ≥ N are unreachable. Grant logic must still treat them as 0, with no X propagation.

Test Plan:
- Reset: N=4, WIDTH=32, assert rst for 2 cycles with all in_valid=1111 -> in_ready=0000 throughout; after release out_valid=0, out_data=0, out_sel=0.
- Round-robin: all channels valid, in_data[i]=0xA0+i, out_ready=1 -> in_ready sequence 0001, 0010, 0100, 1000, 0001; out_sel sequence 0,1,2,3,0 one cycle later; out_data=0xA0..0xA3.
- Backpressure: channel 2 valid with 0xDEADBEEF, out_ready=0 for 3 cycles after capture -> out_valid=1, out_data=0xDEADBEEF, out_sel=2 held; in_ready=0000 during stall; when out_ready=1 a waiting channel 3 is accepted the same cycle.
- Skip and wrap: ptr=3, only channel 1 valid -> grant channel 1, out_sel=1, ptr becomes 2. Then only channel 0 valid -> grant channel 0 after searching 2 and 3.
- Non-power-of-two: N=3, all valid, out_ready=1 -> out_sel sequence 0,1,2,0,1 with no index 3 ever produced.
- Idle and reset mid-stream: drop all in_valid with out_ready=1 -> out_valid=0 next cycle with out_data held. Assert rst while out_valid=1 -> next cycle out_valid=0, and the next grant with all valid is channel 0.
